// File: rtl/wmem_loader.sv
// wmem_loader -- write-side weight-memory loader.
//
// Accepts packed binary weight words over a valid/ready handshake and writes
// them to consecutive weight-memory addresses starting at 0. The number of
// words comes from end_count_i, latched when start_i is accepted in IDLE.
// An end count of N produces writes to addresses 0..N-1, which is the range
// the read-side counter walks when it is run with the same end count.
//
// Optional feature macro: WMEM_LOADER_CHKSUM_EN
//   When defined, adds chksum_o: the running XOR of every word written in
//   the current load. It is cleared on accepted start, includes the final
//   word in the fin cycle, and holds in IDLE.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle load request, honoured only in IDLE
//   end_count_i    words to load, sampled on accepted start
//   in_valid_i     in_data_i holds a weight word
//   in_ready_o     loader accepts a word this cycle (registered)
//   in_data_i      weight word
//   wmem_we_o      weight-memory write strobe
//   wmem_addr_o    weight-memory write address
//   wmem_wdata_o   weight-memory write data
//   busy_o         high from accepted start until back in IDLE
//   fin_o          one-cycle completion pulse, coincident with last write
//   cur_count_o    words accepted so far in the current load
//   chksum_o       (macro only) running XOR of written words
module wmem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] end_count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              wmem_we_o,
    output logic [ADDR_W-1:0] wmem_addr_o,
    output logic [DATA_W-1:0] wmem_wdata_o,
    output logic              busy_o,
    output logic              fin_o,
    output logic [ADDR_W-1:0] cur_count_o
`ifdef WMEM_LOADER_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] chksum_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              fin_q;

    // A handshake can only happen in LOAD, the one state where in_ready_q is set.
    logic hs;
    assign hs = in_valid_i & in_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            end_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            we_q  <= 1'b0;
            fin_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        end_q  <= end_count_i;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (end_count_i == '0) begin
                            state_q <= FIN;
                            fin_q   <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        we_q    <= 1'b1;
                        addr_q  <= cnt_q;
                        wdata_q <= in_data_i;
                        cnt_q   <= cnt_q + 1'b1;
                        // end_q is nonzero in LOAD, so end_q-1 cannot underflow.
                        if (cnt_q == end_q - 1'b1) begin
                            state_q    <= FIN;
                            fin_q      <= 1'b1;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WMEM_LOADER_CHKSUM_EN
    logic [DATA_W-1:0] chk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            chk_q <= '0;
        end else if (hs) begin
            chk_q <= chk_q ^ in_data_i;
        end
    end

    assign chksum_o = chk_q;
`endif

    assign in_ready_o   = in_ready_q;
    assign wmem_we_o    = we_q;
    assign wmem_addr_o  = addr_q;
    assign wmem_wdata_o = wdata_q;
    assign busy_o       = busy_q;
    assign fin_o        = fin_q;
    assign cur_count_o  = cnt_q;

endmodule

// File: tb/tb_wmem_loader.sv
// Self-checking bench for wmem_loader. A transaction-level reference model
// (counts of accepted words against the latched length) predicts every output
// each cycle; directed scenarios add literal expectations on top.
module tb_wmem_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] end_count = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              wmem_we;
    logic [ADDR_W-1:0] wmem_addr;
    logic [DATA_W-1:0] wmem_wdata;
    logic              busy;
    logic              fin;
    logic [ADDR_W-1:0] cur_count;
`ifdef WMEM_LOADER_CHKSUM_EN
    logic [DATA_W-1:0] chksum;
`endif

    wmem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .end_count_i (end_count),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .wmem_we_o   (wmem_we),
        .wmem_addr_o (wmem_addr),
        .wmem_wdata_o(wmem_wdata),
        .busy_o      (busy),
        .fin_o       (fin),
        .cur_count_o (cur_count)
`ifdef WMEM_LOADER_CHKSUM_EN
        ,
        .chksum_o    (chksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A load is: busy, a target length, a number of words taken so far, and
    // whether the target has been reached (completion cycle).
    bit                m_busy = 0, m_done = 0, m_fin = 0, m_we = 0;
    int                m_len = 0, m_taken = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_chk = '0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy = 0; m_done = 0; m_fin = 0; m_we = 0;
            m_len = 0; m_taken = 0; m_addr = '0; m_wdata = '0; m_chk = '0;
        end else begin
            m_we = 0; m_fin = 0;
            if (m_busy && m_done) begin
                m_busy = 0; m_done = 0;
            end else if (m_busy) begin
                if (in_valid) begin
                    m_we = 1; m_addr = ADDR_W'(m_taken); m_wdata = in_data;
                    m_chk = m_chk ^ in_data;
                    m_taken++;
                    if (m_taken == m_len) begin m_done = 1; m_fin = 1; end
                end
            end else if (start) begin
                m_busy = 1; m_len = int'(end_count); m_taken = 0; m_chk = '0;
                if (m_len == 0) begin m_done = 1; m_fin = 1; end
            end
        end
    end

    // ---------------- compare process + write capture ----------------
    logic [DATA_W-1:0] wmem [0:8191];
    logic [DATA_W-1:0] dat  [0:8191];
    int                wr_cnt, fin_cnt;
    logic [ADDR_W-1:0] last_addr, fin_addr;
    logic              fin_we;

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("ctrl{rdy,busy,fin,we}", {28'd0, in_ready, busy, fin, wmem_we},
                  {28'd0, m_busy && !m_done, m_busy, m_fin, m_we});
            check("wmem_addr", 32'(wmem_addr), 32'(m_addr));
            check("wmem_wdata", wmem_wdata, m_wdata);
            check("cur_count", 32'(cur_count), 32'(m_taken));
`ifdef WMEM_LOADER_CHKSUM_EN
            check("chksum", chksum, m_chk);
`endif
            if (wmem_we) begin
                wmem[wmem_addr] = wmem_wdata;
                wr_cnt++;
                last_addr = wmem_addr;
            end
            if (fin) begin
                fin_cnt++;
                fin_addr = wmem_addr;
                fin_we = wmem_we;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] pat = 6'b101001;   // valid sequence 1,0,0,1,0,1 read LSB first

    // mode 0: valid always high, 1: gap pattern, 2: random valid.
    // poke >= 0: cycle at which start is re-pulsed with end_count=2800.
    // abort_at > 0: assert reset after that many accepted words.
    task automatic run_load(input int n, input int mode, input int poke, input int abort_at);
        int   idx, cyc;
        logic v, r;
        wr_cnt = 0; fin_cnt = 0; last_addr = '1; fin_addr = '1; fin_we = 1'b0;
        @(negedge clk);
        start = 1'b1; end_count = ADDR_W'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < n && cyc < 20000) begin
            if (abort_at > 0 && idx == abort_at) break;
            start = (cyc == poke);
            if (cyc == poke) end_count = 13'd2800;
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = pat[cyc % 6];
            else v = 1'($urandom_range(0, 1));
            in_valid = v; in_data = dat[idx]; r = in_ready;
            @(negedge clk);
            if (v && r) idx++;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        if (abort_at > 0) begin
            #2 rst_ni = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 0);
            check("abort_we", 32'(wmem_we), 0);
            check("abort_count", 32'(cur_count), 0);
            repeat (2) @(negedge clk);
            rst_ni = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            if (idx < n) check("load_timeout", 32'(idx), 32'(n));
            for (int i = 0; i < 6 && busy; i++) @(negedge clk);
            check("busy_drop", 32'(busy), 0);
        end
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        #2;
        check("rst_outs", {26'd0, in_ready, wmem_we, busy, fin, 2'b00},
              32'd0);
        check("rst_count", 32'(cur_count), 0);

        // start without data: LOAD the next cycle, then finish it off.
        start = 1'b1; end_count = 13'd1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h55;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Basic load 0xA0..0xA3.
        for (int i = 0; i < 4; i++) dat[i] = 32'hA0 + i;
        run_load(4, 0, -1, 0);
        check("basic_wr_cnt", wr_cnt, 4);
        check("basic_mem0", wmem[0], 32'hA0);
        check("basic_mem3", wmem[3], 32'hA3);
        check("basic_fin_addr", 32'(fin_addr), 3);
        check("basic_fin_we", 32'(fin_we), 1);
        check("basic_fin_cnt", fin_cnt, 1);
        check("basic_cur_count", 32'(cur_count), 4);

        // Backpressure gaps.
        for (int i = 0; i < 3; i++) dat[i] = 32'hB0 + i;
        run_load(3, 1, -1, 0);
        check("gap_wr_cnt", wr_cnt, 3);
        check("gap_mem2", wmem[2], 32'hB2);
        check("gap_last_addr", 32'(last_addr), 2);

        // Zero length.
        run_load(0, 0, -1, 0);
        check("zero_wr_cnt", wr_cnt, 0);
        check("zero_fin_cnt", fin_cnt, 1);

        // Start while busy with a new end_count.
        for (int i = 0; i < 83; i++) dat[i] = $urandom;
        run_load(83, 2, 20, 0);
        check("rstart_wr_cnt", wr_cnt, 83);
        check("rstart_last_addr", 32'(last_addr), 82);
        check("rstart_cur_count", 32'(cur_count), 83);

        // Random loads.
        for (int t = 0; t < 6; t++) begin
            int n;
            bit ok;
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) dat[i] = $urandom;
            run_load(n, 2, -1, 0);
            ok = 1'b1;
            for (int i = 0; i < n; i++) if (wmem[i] !== dat[i]) ok = 1'b0;
            check("rand_memdata", 32'(ok), 1);
            check("rand_wr_cnt", wr_cnt, n);
        end

        // Mid-load reset after 10 writes.
        for (int i = 0; i < 40; i++) dat[i] = 32'hC00 + i;
        run_load(40, 0, -1, 10);
        check("abort_wr_cnt", wr_cnt, 10);
        check("abort_fin_cnt", fin_cnt, 0);

        // Maximum length.
        for (int i = 0; i < 8191; i++) dat[i] = 32'(i) ^ 32'h5A5A0000;
        run_load(8191, 0, -1, 0);
        check("max_wr_cnt", wr_cnt, 8191);
        check("max_last_addr", 32'(last_addr), 8190);
        check("max_cur_count", 32'(cur_count), 8191);
        check("max_mem_last", wmem[8190], 32'h5A5A1FFE);

`ifdef WMEM_LOADER_CHKSUM_EN
        dat[0] = 32'h0F; dat[1] = 32'hF0; dat[2] = 32'hFF;
        run_load(3, 0, -1, 0);
        check("chk_fin_xor", chksum, 32'h00);
        dat[0] = 32'h12;
        run_load(1, 0, -1, 0);
        check("chk_single", chksum, 32'h12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
